// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters driving a decoded one-hot grant.
// Optional forced revoke after HOLD_MAX grant cycles when RR_TIMEOUT_EN is defined.
module rr_decode_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       expired
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [2:0] idx, idx_n;
    logic [7:0] gnt_q, gnt_n;
    logic       valid_q, valid_n;
    logic       exp_q, exp_n;
    logic       timeout_hit;
    logic       found;
    logic [2:0] win;
    logic [2:0] cand;

`ifdef RR_TIMEOUT_EN
    logic [CNT_W-1:0] cnt, cnt_n;
`endif

    if (HOLD_MAX < 1 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_param_check
        $error("rr_decode_arbiter: HOLD_MAX must be 1..255 and fit in CNT_W bits");
    end

    // Circular priority search starting at ptr, ascending with wrap 7->0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr + i[2:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            idx     <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            exp_q   <= 1'b0;
`ifdef RR_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            idx     <= idx_n;
            gnt_q   <= gnt_n;
            valid_q <= valid_n;
            exp_q   <= exp_n;
`ifdef RR_TIMEOUT_EN
            cnt     <= cnt_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        idx_n       = idx;
        timeout_hit = 1'b0;
`ifdef RR_TIMEOUT_EN
        cnt_n       = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (en && found) begin
                    state_n = GRANT;
                    idx_n   = win;
                    ptr_n   = win + 3'd1;
`ifdef RR_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            GRANT: begin
                // A release on the limit cycle takes precedence over the revoke.
                if (!req[idx]) begin
                    state_n = IDLE;
`ifdef RR_TIMEOUT_EN
                end else if (cnt == CNT_W'(HOLD_MAX - 1)) begin
                    state_n     = IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        valid_n = (state_n == GRANT);
        gnt_n   = valid_n ? (8'h01 << idx_n) : '0;
        exp_n   = timeout_hit;
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx;
    assign gnt_valid = valid_q;
`ifdef RR_TIMEOUT_EN
    assign expired   = exp_q;
`else
    assign expired   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench for rr_decode_arbiter; expected output words are queued per driven cycle.
// Builds the RR_TIMEOUT_EN scenario instead of the indefinite-hold scenario when that macro is defined.
module tb_rr_decode_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       expired;
    logic [12:0] obs;
    logic [12:0] expv;
    logic [12:0] sb[$];
    int total = 0;
    int bad = 0;

    rr_decode_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .req(req),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .expired(expired)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, gnt_idx, gnt_valid, expired};

    function automatic logic [12:0] mk(input logic [7:0] g, input logic [2:0] i,
                                       input logic v, input logic x);
        return {g, i, v, x};
    endfunction

    // Called at a falling edge: apply inputs, queue the output expected after the next rising edge.
    task automatic drive(input logic [7:0] r, input logic e, input logic [12:0] x);
        req = r;
        en  = e;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        req   = 8'h00;
        en    = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        expv = mk(8'h00, 3'd0, 1'b0, 1'b0);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", obs, expv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(8'h00, 1'b1, mk(8'h00, 3'd0, 1'b0, 1'b0));
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL idle_no_req cyc=%0d got=%h exp=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  r[6] = '{8'h81, 8'h80, 8'h80, 8'h00, 8'h03, 8'h00};
        logic [12:0] x[6];
        x[0] = mk(8'h01, 3'd0, 1'b1, 1'b0);
        x[1] = mk(8'h00, 3'd0, 1'b0, 1'b0);
        x[2] = mk(8'h80, 3'd7, 1'b1, 1'b0);
        x[3] = mk(8'h00, 3'd7, 1'b0, 1'b0);
        x[4] = mk(8'h01, 3'd0, 1'b1, 1'b0);
        x[5] = mk(8'h00, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(r[i], 1'b1, x[i]);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL wrap step=%0d got=%h exp=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_rotation();
        logic [2:0] o;
        logic [7:0] oh;
        apply_reset();
        o = 3'd0;
        for (int g = 0; g < 9; g++) begin
            oh = 8'h01 << o;
            for (int c = 0; c < 4; c++) begin
                if (c < 3) drive(8'hFF, 1'b1, mk(oh, o, 1'b1, 1'b0));
                else       drive(8'hFF & ~oh, 1'b1, mk(8'h00, o, 1'b0, 1'b0));
                expv = sb.pop_front();
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL rotation grant=%0d cyc=%0d got=%h exp=%h", g, c, obs, expv);
                end
            end
            o = o + 3'd1;
        end
    endtask

    task automatic test_enable();
        logic [7:0]  r[8] = '{8'h08, 8'h08, 8'h18, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};
        logic        e[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [12:0] x[8];
        x[0] = mk(8'h08, 3'd3, 1'b1, 1'b0);
        x[1] = mk(8'h08, 3'd3, 1'b1, 1'b0);
        x[2] = mk(8'h08, 3'd3, 1'b1, 1'b0);
        x[3] = mk(8'h00, 3'd3, 1'b0, 1'b0);
        x[4] = mk(8'h00, 3'd3, 1'b0, 1'b0);
        x[5] = mk(8'h00, 3'd3, 1'b0, 1'b0);
        x[6] = mk(8'h10, 3'd4, 1'b1, 1'b0);
        x[7] = mk(8'h00, 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(r[i], e[i], x[i]);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL enable step=%0d got=%h exp=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(8'h20, 1'b1, mk(8'h20, 3'd5, 1'b1, 1'b0));
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL pre_reset_grant cyc=%0d got=%h exp=%h", i, obs, expv);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0));
        expv = sb.pop_front();
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", obs, expv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // 8'h60: a stale ptr of 6 would pick bit 6, a cleared ptr picks bit 5.
        drive(8'h60, 1'b1, mk(8'h20, 3'd5, 1'b1, 1'b0));
        expv = sb.pop_front();
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL post_reset_grant got=%h exp=%h", obs, expv);
        end
        drive(8'h00, 1'b1, mk(8'h00, 3'd5, 1'b0, 1'b0));
        expv = sb.pop_front();
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL post_reset_release got=%h exp=%h", obs, expv);
        end
    endtask

`ifdef RR_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            if (i < 4)       drive(8'h06, 1'b1, mk(8'h02, 3'd1, 1'b1, 1'b0));
            else if (i == 4) drive(8'h06, 1'b1, mk(8'h00, 3'd1, 1'b0, 1'b1));
            else if (i < 9)  drive(8'h06, 1'b1, mk(8'h04, 3'd2, 1'b1, 1'b0));
            else if (i == 9) drive(8'h06, 1'b1, mk(8'h00, 3'd2, 1'b0, 1'b1));
            else if (i == 10) drive(8'h06, 1'b1, mk(8'h02, 3'd1, 1'b1, 1'b0));
            else             drive(8'h00, 1'b1, mk(8'h00, 3'd1, 1'b0, 1'b0));
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", i, obs, expv);
            end
        end
    endtask
`else
    task automatic test_hold();
        for (int i = 0; i < 21; i++) begin
            if (i < 20) drive(8'h08, 1'b1, mk(8'h08, 3'd3, 1'b1, 1'b0));
            else        drive(8'h00, 1'b1, mk(8'h00, 3'd3, 1'b0, 1'b0));
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL long_hold cyc=%0d got=%h exp=%h", i, obs, expv);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wrap();
        test_rotation();
        test_enable();
        test_async_reset();
`ifdef RR_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
